// File: rtl/regfile_mp.sv
// Multi-read-port register file with a post-reset clear sweep and optional load scoreboard.
// Latency: reads are registered, so data appears one clock after rd_en; writes land on the next clock edge.
// Backpressure: none. rd_en low stalls a port, which then holds its rddata and rd_busy.
//
// Ports:
//   clk, rst_n          single clock; asynchronous active-low reset
//   ready               high once the post-reset clear sweep has finished
//   rd_en/rdaddr        per-port read request (port i at slice i)
//   rddata/rd_busy      per-port registered read data and busy flag
//   wen0/wraddr0/wrdata0  write port 0 (ALU writeback)
//   wen1/wraddr1/wrdata1  write port 1 (load writeback; wins address conflicts)
//   sb_set/sb_addr      mark a register pending because a load was issued
//
// Build option: define REGFILE_SCOREBOARD_EN to add the NREG-bit busy vector.
// Without it, rd_busy is tied to 0 and sb_set/sb_addr are ignored.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                ready,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rdaddr,
  output logic [NRD*XLEN-1:0] rddata,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wen0,
  input  logic [AW-1:0]       wraddr0,
  input  logic [XLEN-1:0]     wrdata0,
  input  logic                wen1,
  input  logic [AW-1:0]       wraddr1,
  input  logic [XLEN-1:0]     wrdata1,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr
);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t          state;
  state_t          state_nxt;
  // One bit wider than an address so the count can reach NREG without wrapping.
  logic [AW:0]     cnt;
  logic [XLEN-1:0] mem [NREG];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_CLEAR) cnt <= cnt + (AW+1)'(1);
    end
  end

  // Next-state logic. READY is only left through reset.
  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && cnt == (AW+1)'(NREG-1)) state_nxt = S_READY;
  end

  // Output logic.
  always_comb begin
    ready = (state == S_READY);
  end

  // Storage has no reset so it can map onto RAM. The sweep zeroes it instead.
  // Port 1 is written last, so it wins when both ports hit the same address.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[cnt[AW-1:0]] <= '0;
    end else begin
      if (wen0 && wraddr0 != '0) mem[wraddr0] <= wrdata0;
      if (wen1 && wraddr1 != '0) mem[wraddr1] <= wrdata1;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Apply the load-return clear first, then the new set, so a set wins a conflict.
  // x0 can never be pending.
  always_comb begin
    busy_nxt = busy;
    if (wen1)   busy_nxt[wraddr1] = 1'b0;
    if (sb_set) busy_nxt[sb_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     busy <= '0;
    else if (ready) busy <= busy_nxt;
  end
`else
  assign rd_busy = '0;
  logic sb_unused;
  assign sb_unused = ^{sb_set, sb_addr};
`endif

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] byp;
    logic [XLEN-1:0] rd_q;

    assign addr = rdaddr[i*AW +: AW];

    // Write-first bypass: port 1 first, then port 0, then storage. x0 is always zero.
    always_comb begin
      byp = mem[addr];
      if (addr == '0)                    byp = '0;
      else if (wen1 && wraddr1 == addr)  byp = wrdata1;
      else if (wen0 && wraddr0 == addr)  byp = wrdata0;
    end

    // During the sweep the read registers are never updated, so they stay at their reset value of 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 rd_q <= '0;
      else if (ready && rd_en[i]) rd_q <= byp;
    end

    assign rddata[i*XLEN +: XLEN] = rd_q;

`ifdef REGFILE_SCOREBOARD_EN
    logic bq;
    // Sample the post-update busy state, so a bypassed load return reads as not busy.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 bq <= 1'b0;
      else if (ready && rd_en[i]) bq <= busy_nxt[addr];
    end
    assign rd_busy[i] = bq;
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                ready;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rdaddr;
  logic [NRD*XLEN-1:0] rddata;
  logic [NRD-1:0]      rd_busy;
  logic                wen0, wen1, sb_set;
  logic [AW-1:0]       wraddr0, wraddr1, sb_addr;
  logic [XLEN-1:0]     wrdata0, wrdata1;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .rd_en(rd_en), .rdaddr(rdaddr), .rddata(rddata), .rd_busy(rd_busy),
    .wen0(wen0), .wraddr0(wraddr0), .wrdata0(wrdata0),
    .wen1(wen1), .wraddr1(wraddr1), .wrdata1(wrdata1),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              port;
    logic [XLEN-1:0] data;
    logic            busy;
    string           name;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
    end
  endtask

  // Issue a read on port p and queue the response it should produce one edge later.
  // Call ports in ascending order within a cycle, because the monitor pops in that order.
  task automatic rd(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                    input logic b, input string n);
    exp_t e;
    rd_en[p] = 1'b1;
    rdaddr[p*AW +: AW] = a;
    e.port = p; e.data = d; e.busy = b; e.name = n;
    q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    wen0 = 1'b0; wen1 = 1'b0; sb_set = 1'b0; rd_en = '0;
  endtask

  // Expect ready to be low for NREG-1 edges after release and high at edge NREG,
  // with the read outputs still at 0 throughout the sweep.
  task automatic sweep_check(input string tag);
    for (int e = 1; e <= NREG; e++) begin
      @(posedge clk); #1;
      check($sformatf("%s_ready_e%0d", tag, e), 64'(ready), 64'(e == NREG));
      if (e == 10 || e == NREG - 1)
        check($sformatf("%s_rd0_e%0d", tag, e), 64'({rd_busy, rddata}), 64'd0);
    end
    @(negedge clk);
  endtask

  // Monitor: every edge that sees rd_en[i] high produces one response on port i.
  initial begin
    logic [NRD-1:0] en;
    exp_t e;
    forever begin
      @(posedge clk);
      en = rd_en;
      #1;
      for (int i = 0; i < NRD; i++) begin
        if (en[i]) begin
          if (q.size() == 0) begin
            check($sformatf("underflow_p%0d", i), 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            check($sformatf("%s_port", e.name), 64'(i), 64'(e.port));
            check(e.name, 64'({rd_busy[i], rddata[i*XLEN +: XLEN]}), 64'({e.busy, e.data}));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rd_en = '0; rdaddr = '0;
    wen0 = 1'b0; wen1 = 1'b0; sb_set = 1'b0;
    wraddr0 = '0; wraddr1 = '0; sb_addr = '0; wrdata0 = '0; wrdata1 = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_rd", 64'({rd_busy, rddata}), 64'd0);
    rst_n = 1'b1;
    sweep_check("sweep0");

    // Every register reads zero after the sweep.
    for (int a = 0; a < 16; a++) begin
      rd(0, AW'(a), 32'h0, 1'b0, $sformatf("zero_x%0d", a));
      rd(1, AW'(a + 16), 32'h0, 1'b0, $sformatf("zero_x%0d", a + 16));
      tick();
    end

    // A same-address double write: port 1 wins.
    wen0 = 1'b1; wraddr0 = 5'd5; wrdata0 = 32'h1234;
    wen1 = 1'b1; wraddr1 = 5'd5; wrdata1 = 32'hBEEF;
    tick();
    rd(0, 5'd5, 32'hBEEF, 1'b0, "x5_p1wins_p0");
    rd(1, 5'd5, 32'hBEEF, 1'b0, "x5_p1wins_p1");
    tick();

    // Same-cycle write and read of x7 bypasses the write.
    wen0 = 1'b1; wraddr0 = 5'd7; wrdata0 = 32'hA5A5A5A5;
    rd(0, 5'd5, 32'hBEEF, 1'b0, "x5_again");
    rd(1, 5'd7, 32'hA5A5A5A5, 1'b0, "x7_bypass");
    tick();
    rd(0, 5'd7, 32'hA5A5A5A5, 1'b0, "x7_stored");
    tick();

    // Both write ports hit x9: the bypass takes port 1. Port 0 alone bypasses x10.
    wen0 = 1'b1; wraddr0 = 5'd9;  wrdata0 = 32'h22;
    wen1 = 1'b1; wraddr1 = 5'd9;  wrdata1 = 32'h33;
    rd(0, 5'd9, 32'h33, 1'b0, "x9_bypass_p1");
    tick();
    wen0 = 1'b1; wraddr0 = 5'd10; wrdata0 = 32'h44;
    rd(1, 5'd10, 32'h44, 1'b0, "x10_bypass_p0");
    tick();

    // Writes to x0 are discarded, including a same-cycle bypass.
    wen0 = 1'b1; wraddr0 = 5'd0; wrdata0 = 32'hFFFFFFFF;
    wen1 = 1'b1; wraddr1 = 5'd0; wrdata1 = 32'hFFFFFFFF;
    rd(0, 5'd0, 32'h0, 1'b0, "x0_samecycle");
    tick();
    rd(0, 5'd0, 32'h0, 1'b0, "x0_p0");
    rd(1, 5'd0, 32'h0, 1'b0, "x0_p1");
    tick();

    // With rd_en low, the read outputs hold while the address and storage change.
    rd(0, 5'd5, 32'hBEEF, 1'b0, "hold_pre_p0");
    rd(1, 5'd7, 32'hA5A5A5A5, 1'b0, "hold_pre_p1");
    tick();
    rdaddr = '0;
    wen0 = 1'b1; wraddr0 = 5'd5; wrdata0 = 32'h1111;
    tick(); tick(); tick();
    check("hold_p0", 64'(rddata[0 +: XLEN]), 64'h0000BEEF);
    check("hold_p1", 64'(rddata[XLEN +: XLEN]), 64'hA5A5A5A5);
    rd(0, 5'd5, 32'h1111, 1'b0, "x5_after_hold");
    tick();

`ifdef REGFILE_SCOREBOARD_EN
    sb_set = 1'b1; sb_addr = 5'd3;
    tick();
    rd(0, 5'd3, 32'h0, 1'b1, "sb_x3_busy");
    tick();
    wen1 = 1'b1; wraddr1 = 5'd3; wrdata1 = 32'd9;
    rd(0, 5'd3, 32'd9, 1'b0, "sb_x3_return");
    tick();
    sb_set = 1'b1; sb_addr = 5'd3;
    wen1 = 1'b1; wraddr1 = 5'd3; wrdata1 = 32'd5;
    tick();
    rd(1, 5'd3, 32'd5, 1'b1, "sb_set_wins");
    tick();
    wen1 = 1'b1; wraddr1 = 5'd3; wrdata1 = 32'd6;
    tick();
    rd(0, 5'd3, 32'd6, 1'b0, "sb_cleared");
    tick();
    sb_set = 1'b1; sb_addr = 5'd0;
    tick();
    rd(0, 5'd0, 32'h0, 1'b0, "sb_x0_never");
    tick();
`else
    sb_set = 1'b1; sb_addr = 5'd3;
    tick();
    rd(0, 5'd3, 32'h0, 1'b0, "nosb_x3");
    tick();
`endif
    tick();

    // Reset mid-sweep restarts the full sweep.
    rst_n = 1'b0; #1;
    check("rst_async_ready", 64'(ready), 64'd0);
    check("rst_async_rd", 64'({rd_busy, rddata}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mid_ready", 64'(ready), 64'd0);
    rst_n = 1'b0; #1;
    check("mid_rd", 64'({rd_busy, rddata}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_check("sweep1");
    rd(0, 5'd5, 32'h0, 1'b0, "x5_cleared");
    rd(1, 5'd7, 32'h0, 1'b0, "x7_cleared");
    tick();

    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
    check("drain", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count; power of two, 2..64; AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2, read port count, 1..4; read buses flattened with port i at slice i.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port ready  output  1  high once the post-reset clear sweep has completed.
REQ-007 SHALL have port rd_en  input  NRD  per-port read enable.
REQ-008 SHALL have port rdaddr  input  NRD*AW  per-port read address.
REQ-009 SHALL have port rddata  output  NRD*XLEN  per-port registered read data.
REQ-010 SHALL have port rd_busy  output  NRD  per-port registered scoreboard busy flag.
REQ-011 SHALL have ports wen0 / wraddr0 / wrdata0  input  1/AW/XLEN  write port 0 (ALU writeback).
REQ-012 SHALL have ports wen1 / wraddr1 / wrdata1  input  1/AW/XLEN  write port 1 (load writeback).
REQ-013 SHALL have ports sb_set / sb_addr  input  1/AW  mark a register pending (load issued).

Function
REQ-014 SHALL run a two-state FSM: CLEAR, then READY; there is no transition from READY back to CLEAR except via reset.
REQ-015 In CLEAR, SHALL write zero to register cnt each cycle, with cnt running 0..NREG-1; after the write of NREG-1, SHALL enter READY; ready rises on edge NREG after reset release.
REQ-016 In CLEAR, SHALL ignore wen0, wen1 and sb_set; rddata and rd_busy SHALL hold 0.
REQ-017 In READY, SHALL write wrdata0 at wen0 and write wrdata1 at wen1; writes to address 0 SHALL be discarded.
REQ-018 When wen0 and wen1 target the same nonzero address in the same cycle, port 1 SHALL win.
REQ-019 Read latency SHALL be 1 cycle: with rd_en[i]=1 at edge k, rddata[i] SHALL show the value from edge k onward.
REQ-020 With rd_en[i]=0, rddata[i] and rd_busy[i] SHALL hold their previous values (stall).
REQ-021 Read of address 0 SHALL return 0.
REQ-022 A read SHALL bypass same-cycle writes: a match on port 1 returns wrdata1, else a match on port 0 returns wrdata0, else the stored value (write-first).
REQ-023 All arithmetic SHALL be unsigned; cnt SHALL be AW+1 bits wide so it does not wrap before reaching NREG.

Reset
REQ-024 rst_n low SHALL asynchronously force state to CLEAR, cnt to 0, ready to 0, rddata to 0, rd_busy to 0, and all busy bits to 0.
REQ-025 Reset asserted mid-sweep or in READY SHALL restart the full sweep; register contents are not reset directly (RAM inference).

Configuration
REQ-026 Macro REGFILE_SCOREBOARD_EN SHALL enable an NREG-bit busy vector.
REQ-027 With REGFILE_SCOREBOARD_EN defined, sb_set SHALL set busy[sb_addr] and wen1 SHALL clear busy[wraddr1].
REQ-028 With REGFILE_SCOREBOARD_EN defined and set/clear on the same address in the same cycle, set SHALL win; address 0 SHALL never be busy.
REQ-029 With REGFILE_SCOREBOARD_EN defined, rd_busy[i] SHALL register the busy state after this cycle's clear is applied (a bypassed port-1 write reads as not busy).
REQ-030 Without REGFILE_SCOREBOARD_EN, no busy storage SHALL exist, rd_busy SHALL be constant 0, and sb_set/sb_addr SHALL be ignored; ports SHALL remain present.

Verification
REQ-031 Release reset, NREG=32 -> ready=0 for 31 edges and 1 at edge 32; then every register reads 0.
REQ-032 wen0 with x5=0x1234 and wen1 with x5=0xBEEF in the same cycle, then read x5 -> 0xBEEF.
REQ-033 In one cycle, write x7=0xA5A5A5A5 and read x7 on port 1 -> rddata[1]=0xA5A5A5A5 after 1 edge.
REQ-034 Write x0=0xFFFFFFFF, then read x0 -> 0; with rd_en=0 while the address changes -> rddata unchanged.
REQ-035 With REGFILE_SCOREBOARD_EN: sb_set x3, read x3 -> rd_busy=1; wen1 x3=9 with read of x3 in the same cycle -> rddata=9, rd_busy=0; sb_set and wen1 to x3 in the same cycle -> busy stays 1.
REQ-036 Assert rst_n low at cnt=10 of the sweep, then release -> ready=0 until 32 edges after release; rddata=0 throughout.
